input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Parametrised front end for all player/menu buttons. It generates the game tick and, for each
//  of CHANNELS buttons, synchronises, debounces and edge-detects the raw input. Optional
//  hold-to-repeat pulses per channel. Sits between the board pins and the game/menu FSMs.
//  It replaces the ad-hoc tick divider and single-button sampler in the top level.
// PARAMETERS
//  CHANNELS       5     number of button channels (>=1)
//  TICK_DIV       6000  clk cycles per tick pulse (>=2); 12 MHz/6000 = 2 kHz
//  SYNC_STAGES    2     synchroniser flops per channel (>=2)
//  DEBOUNCE_TICKS 20    consecutive ticks the input must differ before btn_level follows (>=1)
//  REPEAT_DELAY   400   ticks from press to first repeat pulse (>=1)
//  REPEAT_RATE    100   ticks between subsequent repeat pulses (>=1)
// PORTS
//  clk          in   1         system clock (12 MHz HSOSC)
//  reset        in   1         asynchronous, active-high reset
//  btn_raw      in   CHANNELS  raw asynchronous button inputs, 1 = pressed
//  repeat_en    in   CHANNELS  per-channel hold-to-repeat enable
//  tick         out  1         one-clk pulse every TICK_DIV clks
//  btn_level    out  CHANNELS  debounced button state
//  btn_press    out  CHANNELS  one-clk pulse on debounced 0->1
//  btn_release  out  CHANNELS  one-clk pulse on debounced 1->0
//  btn_repeat   out  CHANNELS  one-clk auto-repeat pulse while held
// BEHAVIOUR
//  - Reset: all counters, sync flops, FSMs and outputs go to 0 immediately. No pulses during reset.
//  - Tick: tick_cnt is $clog2(TICK_DIV) bits and counts 0..TICK_DIV-1. tick=1 when tick_cnt==TICK_DIV-1,
//    then tick_cnt wraps to 0. First tick is TICK_DIV clks after reset deassertion.
//  - Sync: btn_raw passes through SYNC_STAGES flops, which reset to 0, giving sync[i]. All later
//    logic uses only sync[i].
//  - Debounce: on a tick, if sync!=btn_level then db_cnt+=1, else db_cnt=0. When the increment
//    would reach DEBOUNCE_TICKS, btn_level toggles and db_cnt=0. No change on non-tick cycles.
//  - btn_press and btn_release are registered in the same edge that updates btn_level, so they
//    coincide with the first cycle of the new level and with tick. Each lasts exactly 1 clk.
//  - Repeat FSM per channel (IDLE, DELAY, RPT), rep_cnt wide enough for max(REPEAT_DELAY, REPEAT_RATE):
//    IDLE  -> DELAY on press && repeat_en. rep_cnt=0.
//    DELAY: each tick rep_cnt+=1. On reaching REPEAT_DELAY, btn_repeat=1, go RPT, rep_cnt=0.
//    RPT:   each tick rep_cnt+=1. On reaching REPEAT_RATE, btn_repeat=1, rep_cnt=0.
//    Any state -> IDLE when btn_level is 0 or repeat_en is 0, checked every clk, and no pulse is
//    issued in that cycle. Release has priority over a coincident repeat.
//    btn_repeat never coincides with btn_press. It always coincides with tick.
//  - Channels are fully independent. Simultaneous events on several channels are all reported in
//    the same cycle.
//  - A button held through reset produces btn_press DEBOUNCE_TICKS ticks after sync settles. It
//    never produces a btn_release for the pre-reset press.
//  - Worst-case press latency: SYNC_STAGES clks + DEBOUNCE_TICKS*TICK_DIV clks.
// TESTING (CHANNELS=2, TICK_DIV=4, SYNC_STAGES=2, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2)
//  1 Release reset, inputs 0 -> tick high at clks 4,8,12..., each 1 clk wide. All other outputs stay 0.
//  2 btn_raw[0]=1 held -> btn_level[0] and btn_press[0] rise on the 3rd tick after sync[0]=1.
//    btn_press[0] lasts 1 clk.
//  3 btn_raw[0] high for 2 ticks then low -> no press. db_cnt clears, btn_level[0] stays 0.
//  4 repeat_en[0]=1, hold -> btn_repeat[0] 5 ticks after press, then every 2 ticks. Drop btn_raw
//    -> btn_release[0] 3 ticks later, no repeat pulse after level falls.
//  5 Both held, repeat_en=2'b01 -> press pulses on both in the same cycle. Repeats only on ch0.
//    Clearing repeat_en[0] mid-hold stops repeats immediately.
//  6 Assert reset while ch0 is in RPT -> all outputs 0 in the same cycle (async). After deassertion,
//    with the button still held, a single btn_press follows after 3 ticks and no btn_release.

Source files
------------

// File: rtl/input_conditioner.sv
// Button front end: game tick generation plus per-channel synchronise, debounce,
// edge detect and optional hold-to-repeat. All outputs are registered.
module input_conditioner #(
  parameter int unsigned CHANNELS       = 5,
  parameter int unsigned TICK_DIV       = 6000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned REPEAT_DELAY   = 400,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_raw,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic                tick,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  localparam int unsigned TICK_W  = $clog2(TICK_DIV);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  // ---------------------------------------------------------------------------
  // Tick divider. tick_event marks the edge on which all tick-paced logic
  // advances; the registered tick output rises on that same edge, so every
  // tick-paced output change lines up with the tick pulse.
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_event;

  assign tick_event = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Free-running 0..TICK_DIV-1 counter and registered tick pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= tick_event;
      tick_cnt <= tick_event ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser. Only the last stage (sync) is used downstream.
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_ff [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Multi-flop synchroniser chain for the asynchronous button pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_ff[k] <= '0;
      end
    end else begin
      sync_ff[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_ff[k] <= sync_ff[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce. The level only follows sync after it has differed on
  // DEBOUNCE_TICKS consecutive ticks; press/release are produced alongside the
  // level change so they coincide with the first cycle of the new level.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0]     db_cnt     [CHANNELS];
  logic [DB_W-1:0]     db_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] level_nxt;
  logic [CHANNELS-1:0] press_nxt;
  logic [CHANNELS-1:0] release_nxt;

  // Next debounce count, level and edge pulses for every channel.
  always_comb begin
    level_nxt   = btn_level;
    press_nxt   = '0;
    release_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      db_cnt_nxt[i] = db_cnt[i];
      if (tick_event) begin
        if (sync[i] != btn_level[i]) begin
          if (db_cnt[i] + DB_W'(1) == DB_W'(DEBOUNCE_TICKS)) begin
            db_cnt_nxt[i]  = '0;
            level_nxt[i]   = ~btn_level[i];
            press_nxt[i]   = ~btn_level[i];
            release_nxt[i] = btn_level[i];
          end else begin
            db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt_nxt[i] = '0;
        end
      end
    end
  end

  // Debounce state and the level/edge output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt[i] <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Hold-to-repeat FSM per channel. It looks at the *next* level so that a
  // release on the same tick as a due repeat wins and suppresses the pulse,
  // and it is entered on the press edge itself so counting starts at the
  // following tick.
  // ---------------------------------------------------------------------------
  logic [1:0]          rep_state     [CHANNELS];
  logic [1:0]          rep_state_nxt [CHANNELS];
  logic [REP_W-1:0]    rep_cnt       [CHANNELS];
  logic [REP_W-1:0]    rep_cnt_nxt   [CHANNELS];
  logic [CHANNELS-1:0] repeat_nxt;

  // Repeat FSM next state, counter and pulse.
  always_comb begin
    repeat_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rep_state_nxt[i] = rep_state[i];
      rep_cnt_nxt[i]   = rep_cnt[i];
      if (!level_nxt[i] || !repeat_en[i]) begin
        rep_state_nxt[i] = ST_IDLE;
        rep_cnt_nxt[i]   = '0;
      end else begin
        case (rep_state[i])
          ST_IDLE: begin
            if (press_nxt[i]) begin
              rep_state_nxt[i] = ST_DELAY;
              rep_cnt_nxt[i]   = '0;
            end
          end
          ST_DELAY: begin
            if (tick_event) begin
              if (rep_cnt[i] + REP_W'(1) == REP_W'(REPEAT_DELAY)) begin
                repeat_nxt[i]    = 1'b1;
                rep_state_nxt[i] = ST_RPT;
                rep_cnt_nxt[i]   = '0;
              end else begin
                rep_cnt_nxt[i] = rep_cnt[i] + REP_W'(1);
              end
            end
          end
          ST_RPT: begin
            if (tick_event) begin
              if (rep_cnt[i] + REP_W'(1) == REP_W'(REPEAT_RATE)) begin
                repeat_nxt[i]  = 1'b1;
                rep_cnt_nxt[i] = '0;
              end else begin
                rep_cnt_nxt[i] = rep_cnt[i] + REP_W'(1);
              end
            end
          end
          default: begin
            rep_state_nxt[i] = ST_IDLE;
            rep_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM state register and registered repeat pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rep_state[i] <= ST_IDLE;
        rep_cnt[i]   <= '0;
      end
      btn_repeat <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        rep_state[i] <= rep_state_nxt[i];
        rep_cnt[i]   <= rep_cnt_nxt[i];
      end
      btn_repeat <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios plus random
// button activity, checked cycle by cycle against a tick-counting reference.
module tb_input_conditioner;

  localparam int CH = 2;
  localparam int TD = 4;
  localparam int SS = 2;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic [CH-1:0] btn_raw   = '0;
  logic [CH-1:0] repeat_en = '0;
  logic          tick;
  logic [CH-1:0] btn_level;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic [CH-1:0] btn_repeat;

  int n_cmp = 0;
  int n_bad = 0;

  input_conditioner #(
    .CHANNELS      (CH),
    .TICK_DIV      (TD),
    .SYNC_STAGES   (SS),
    .DEBOUNCE_TICKS(DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .tick       (tick),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  // Reference model: clocks since reset, raw-input history, tick-level counters.
  int            m_since;
  logic          m_tick;
  logic [CH-1:0] m_level, m_press, m_rel, m_rpt, m_act;
  int            m_db   [CH];
  int            m_held [CH];
  logic [CH-1:0] m_sync [SS];

  task automatic model_reset();
    m_since = 0;
    m_tick  = 1'b0;
    m_level = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_act = '0;
    for (int c = 0; c < CH; c++) begin m_db[c] = 0; m_held[c] = 0; end
    for (int k = 0; k < SS; k++) m_sync[k] = '0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    logic s;
    if (reset) begin model_reset(); return; end
    m_since++;
    m_tick  = (m_since % TD == 0);
    m_press = '0; m_rel = '0; m_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      s = m_sync[SS-1][c];
      if (m_tick) begin
        if (s != m_level[c]) begin
          m_db[c]++;
          if (m_db[c] == DB) begin
            m_db[c]    = 0;
            m_level[c] = s;
            if (s) m_press[c] = 1'b1; else m_rel[c] = 1'b1;
          end
        end else begin
          m_db[c] = 0;
        end
      end
      if (!m_level[c] || !repeat_en[c]) begin
        m_act[c] = 1'b0;
      end else if (m_press[c]) begin
        m_act[c]  = 1'b1;
        m_held[c] = 0;
      end else if (m_act[c] && m_tick) begin
        m_held[c]++;
        if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RR == 0)) m_rpt[c] = 1'b1;
      end
    end
    for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = btn_raw;
  endtask

  function automatic logic [4*CH:0] dut_vec();
    return {tick, btn_level, btn_press, btn_release, btn_repeat};
  endfunction

  function automatic logic [4*CH:0] exp_vec();
    return {m_tick, m_level, m_press, m_rel, m_rpt};
  endfunction

  // One clock: edge, model update, then settle before sampling.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_raw = '0; repeat_en = '0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_cmp++;
      if (dut_vec() !== '0) begin
        n_bad++; $display("FAIL reset_hold t=%0t got %b need 0", $time, dut_vec());
      end
    end
    @(negedge clk); reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cyc();
      n_cmp++;
      if (tick !== 1'(k % TD == 0)) begin
        n_bad++; $display("FAIL tick_period clk %0d got %b need %b", k, tick, (k % TD == 0));
      end
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL idle_outputs clk %0d got %b need %b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_press_release();
    int ticks = 0;
    int presses = 0;
    int releases = 0;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (k >= SS && tick) ticks++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL press_hold t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
      if (btn_press[0]) begin
        presses++;
        n_cmp++;
        if (ticks !== DB || tick !== 1'b1) begin
          n_bad++; $display("FAIL press_latency got ticks=%0d tick=%b need ticks=%0d tick=1", ticks, tick, DB);
        end
      end
    end
    n_cmp++;
    if (presses !== 1 || btn_level[0] !== 1'b1) begin
      n_bad++; $display("FAIL press_count got %0d lvl=%b need 1 lvl=1", presses, btn_level[0]);
    end
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (btn_release[0]) releases++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL release_hold t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (releases !== 1 || btn_level[0] !== 1'b0) begin
      n_bad++; $display("FAIL release_count got %0d lvl=%b need 1 lvl=0", releases, btn_level[0]);
    end
  endtask

  task automatic test_glitch();
    int presses = 0;
    int pre = $urandom_range(0, 3);
    for (int k = 0; k < pre; k++) cyc();
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 2 * TD + 20; k++) begin
      cyc();
      if (k == 2 * TD - 1) btn_raw[0] = 1'b0;
      if (btn_press[0]) presses++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL glitch t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (presses !== 0 || btn_level[0] !== 1'b0) begin
      n_bad++; $display("FAIL glitch_ignored got presses=%0d lvl=%b need 0 0", presses, btn_level[0]);
    end
  endtask

  task automatic test_repeat();
    int t = -1;
    int rpts = 0;
    repeat_en = 2'b01;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 110; k++) begin
      if (k == 70) btn_raw[0] = 1'b0;
      cyc();
      if (btn_press[0]) t = 0;
      else if (t >= 0 && tick) t++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL repeat_hold t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
      if (btn_repeat[0]) begin
        rpts++;
        n_cmp++;
        if (!(t == RD || (t > RD && (t - RD) % RR == 0)) || !btn_level[0] || btn_press[0]) begin
          n_bad++; $display("FAIL repeat_timing got tick_idx=%0d lvl=%b need idx %0d+n*%0d lvl=1", t, btn_level[0], RD, RR);
        end
      end
    end
    n_cmp++;
    if (rpts < 3) begin
      n_bad++; $display("FAIL repeat_count got %0d need >=3", rpts);
    end
    repeat_en = '0;
  endtask

  task automatic test_two_channels();
    int both = 0;
    repeat_en = 2'b01;
    btn_raw = 2'b11;
    for (int k = 0; k < 90; k++) begin
      if (k == 50) repeat_en[0] = 1'b0;
      if (k == 60) btn_raw = 2'b00;
      cyc();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL two_ch t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
      if (btn_press !== 2'b00) begin
        n_cmp++;
        if (btn_press !== 2'b11) begin
          n_bad++; $display("FAIL press_together got %b need 11", btn_press);
        end else both++;
      end
      if (btn_repeat[1] || (k >= 50 && btn_repeat[0])) begin
        n_cmp++; n_bad++;
        $display("FAIL repeat_gated k=%0d got %b need 00", k, btn_repeat);
      end
    end
    n_cmp++;
    if (both !== 1) begin
      n_bad++; $display("FAIL press_together_count got %0d need 1", both);
    end
  endtask

  task automatic test_reset_in_rpt();
    int rpts = 0;
    int presses = 0;
    int releases = 0;
    int k = 0;
    repeat_en = 2'b01;
    btn_raw = 2'b01;
    while (rpts < 2 && k < 120) begin
      cyc();
      k++;
      if (btn_repeat[0]) rpts++;
    end
    n_cmp++;
    if (rpts < 2) begin
      n_bad++; $display("FAIL reach_rpt got %0d repeats need 2", rpts);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++; $display("FAIL async_reset got %b need 0", dut_vec());
    end
    cyc(); cyc();
    @(negedge clk); reset = 1'b0;
    for (int j = 0; j < 45; j++) begin
      cyc();
      if (btn_press[0]) presses++;
      if (btn_release[0]) releases++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL post_reset t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (presses !== 1 || releases !== 0) begin
      n_bad++; $display("FAIL held_through_reset got press=%0d rel=%0d need 1 0", presses, releases);
    end
    btn_raw = '0; repeat_en = '0;
    for (int j = 0; j < 30; j++) cyc();
  endtask

  task automatic test_random();
    int left = 0;
    for (int k = 0; k < 1500; k++) begin
      if (left == 0) begin
        btn_raw = CH'($urandom);
        if ($urandom_range(0, 3) == 0) repeat_en = CH'($urandom);
        left = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 60);
      end
      left--;
      cyc();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random t=%0t got %b need %b", $time, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_repeat();
    test_two_channels();
    test_reset_in_rpt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
